tile_scheduler: RTL

TILE_SCHEDULER -- requirements
Module: tile_scheduler

---
 rtl/tile_scheduler_pkg.sv | 28 ++
 rtl/tile_scheduler_if.sv | 39 +++
 rtl/tile_addr_gen.sv | 103 ++++++++++
 rtl/tile_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tile_scheduler_pkg.sv
// Shared types and default geometry for the tiled matrix-multiply scheduler.
// Imported by the interface, the address generator and the scheduler top.
package tile_sched_pkg;

  localparam int unsigned DEF_MATRIX_DIM = 32'd16;
  localparam int unsigned DEF_TILE_DIM   = 32'd4;
  localparam int unsigned TILES_PER_DIM  = DEF_MATRIX_DIM / DEF_TILE_DIM;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } sched_state_e;

  // Counter width for a count of n positions; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/tile_scheduler_if.sv
// Handshake bundle between the tile scheduler, its starter and the systolic array.
// The scheduler side uses the master modport; stimulus/array side uses slave.
interface tile_scheduler_if
  import tile_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = $clog2(DEF_MATRIX_DIM * DEF_MATRIX_DIM),
  parameter int unsigned POS_WIDTH  = idx_width(DEF_TILE_DIM)
);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_a_addr;
  logic [ADDR_WIDTH-1:0] ld_b_addr;
  logic [POS_WIDTH-1:0]  ld_row;
  logic [POS_WIDTH-1:0]  ld_col;
  logic                  arr_start;
  logic                  arr_clear_acc;
  logic                  arr_done;
  logic                  wb_valid;
  logic [POS_WIDTH-1:0]  wb_row;
  logic [POS_WIDTH-1:0]  wb_col;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  proto_err;

  modport master (
    input  start, arr_done,
    output busy, done, ld_valid, ld_a_addr, ld_b_addr, ld_row, ld_col,
           arr_start, arr_clear_acc, wb_valid, wb_row, wb_col, wb_addr, proto_err
  );

  modport slave (
    output start, arr_done,
    input  busy, done, ld_valid, ld_a_addr, ld_b_addr, ld_row, ld_col,
           arr_start, arr_clear_acc, wb_valid, wb_row, wb_col, wb_addr, proto_err
  );

endinterface

// File: rtl/tile_addr_gen.sv
// Beat counter (r outer, c inner) and registered A/B/C element addresses.
// Addresses are computed from next-cycle indices so they line up with the valids.
module tile_addr_gen
  import tile_sched_pkg::*;
#(
  parameter int unsigned MATRIX_DIM = DEF_MATRIX_DIM,
  parameter int unsigned TILE_DIM   = DEF_TILE_DIM,
  parameter int unsigned ADDR_WIDTH = $clog2(MATRIX_DIM * MATRIX_DIM),
  parameter int unsigned IDX_W      = idx_width(MATRIX_DIM / TILE_DIM),
  parameter int unsigned POS_W      = idx_width(TILE_DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_s,
  input  logic                  adv_s,
  input  logic                  ld_en_s,
  input  logic                  wb_en_s,
  input  logic [IDX_W-1:0]      ti_s,
  input  logic [IDX_W-1:0]      tj_s,
  input  logic [IDX_W-1:0]      tk_s,
  output logic                  beat_last_s,
  output logic [POS_W-1:0]      ld_row_r,
  output logic [POS_W-1:0]      ld_col_r,
  output logic [POS_W-1:0]      wb_row_r,
  output logic [POS_W-1:0]      wb_col_r,
  output logic [ADDR_WIDTH-1:0] ld_a_addr_r,
  output logic [ADDR_WIDTH-1:0] ld_b_addr_r,
  output logic [ADDR_WIDTH-1:0] wb_addr_r
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(TILE_DIM - 32'd1);

  logic [POS_W-1:0] r_r;
  logic [POS_W-1:0] c_r;
  logic [POS_W-1:0] r_nx_s;
  logic [POS_W-1:0] c_nx_s;

  // Row-major element address of position (r, c) inside tile (tile_row, tile_col).
  function automatic logic [ADDR_WIDTH-1:0] elem_addr(
    input logic [IDX_W-1:0] tile_row,
    input logic [IDX_W-1:0] tile_col,
    input logic [POS_W-1:0] r,
    input logic [POS_W-1:0] c
  );
    logic [ADDR_WIDTH-1:0] row_s;
    logic [ADDR_WIDTH-1:0] col_s;
    row_s = ADDR_WIDTH'(tile_row) * ADDR_WIDTH'(TILE_DIM) + ADDR_WIDTH'(r);
    col_s = ADDR_WIDTH'(tile_col) * ADDR_WIDTH'(TILE_DIM) + ADDR_WIDTH'(c);
    return row_s * ADDR_WIDTH'(MATRIX_DIM) + col_s;
  endfunction

  assign beat_last_s = (r_r == POS_LAST) && (c_r == POS_LAST);

  // Next beat position: cleared on run start, advanced c-first with wrap.
  always_comb begin
    r_nx_s = r_r;
    c_nx_s = c_r;
    if (clr_s) begin
      r_nx_s = '0;
      c_nx_s = '0;
    end else if (adv_s) begin
      if (c_r == POS_LAST) begin
        c_nx_s = '0;
        if (r_r == POS_LAST) begin
          r_nx_s = '0;
        end else begin
          r_nx_s = r_r + POS_W'(1);
        end
      end else begin
        c_nx_s = c_r + POS_W'(1);
      end
    end else begin
      r_nx_s = r_r;
      c_nx_s = c_r;
    end
  end

  // Beat counter and registered address/position outputs, zero when not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r         <= '0;
      c_r         <= '0;
      ld_row_r    <= '0;
      ld_col_r    <= '0;
      wb_row_r    <= '0;
      wb_col_r    <= '0;
      ld_a_addr_r <= '0;
      ld_b_addr_r <= '0;
      wb_addr_r   <= '0;
    end else begin
      r_r         <= r_nx_s;
      c_r         <= c_nx_s;
      ld_row_r    <= ld_en_s ? r_nx_s : '0;
      ld_col_r    <= ld_en_s ? c_nx_s : '0;
      wb_row_r    <= wb_en_s ? r_nx_s : '0;
      wb_col_r    <= wb_en_s ? c_nx_s : '0;
      ld_a_addr_r <= ld_en_s ? elem_addr(ti_s, tk_s, r_nx_s, c_nx_s) : '0;
      ld_b_addr_r <= ld_en_s ? elem_addr(tk_s, tj_s, r_nx_s, c_nx_s) : '0;
      wb_addr_r   <= wb_en_s ? elem_addr(ti_s, tj_s, r_nx_s, c_nx_s) : '0;
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Sequences load / compute / writeback over all (ti, tj, tk) tiles of C = A * B.
// All outputs are flops fed from next-state values so they align with the state.
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int unsigned MATRIX_DIM = DEF_MATRIX_DIM,
  parameter int unsigned TILE_DIM   = DEF_TILE_DIM,
  parameter int unsigned ADDR_WIDTH = $clog2(MATRIX_DIM * MATRIX_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  tile_scheduler_if.master  bus
);

  localparam int unsigned TPD   = MATRIX_DIM / TILE_DIM;
  localparam int unsigned IDX_W = idx_width(TPD);
  localparam int unsigned POS_W = idx_width(TILE_DIM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TPD - 32'd1);

  sched_state_e     state_r;
  sched_state_e     state_nx_s;
  logic [IDX_W-1:0] ti_r, tj_r, tk_r;
  logic [IDX_W-1:0] ti_nx_s, tj_nx_s, tk_nx_s;
  logic             clr_s;
  logic             adv_s;
  logic             beat_last_s;
  logic             proto_err_nx_s;

  logic busy_r, done_r, ld_valid_r, arr_start_r, arr_clear_acc_r, wb_valid_r, proto_err_r;

  // Next state, tile indices and beat-counter control.
  always_comb begin
    state_nx_s = state_r;
    ti_nx_s    = ti_r;
    tj_nx_s    = tj_r;
    tk_nx_s    = tk_r;
    clr_s      = 1'b0;
    adv_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_nx_s = S_LOAD;
          ti_nx_s    = '0;
          tj_nx_s    = '0;
          tk_nx_s    = '0;
          clr_s      = 1'b1;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_LOAD: begin
        adv_s = 1'b1;
        if (beat_last_s) begin
          state_nx_s = S_ISSUE;
        end else begin
          state_nx_s = S_LOAD;
        end
      end
      S_ISSUE: state_nx_s = S_WAIT;
      S_WAIT: begin
        if (bus.arr_done) begin
          if (tk_r == IDX_LAST) begin
            state_nx_s = S_WB;
          end else begin
            state_nx_s = S_NEXT;
          end
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      S_WB: begin
        adv_s = 1'b1;
        if (beat_last_s) begin
          state_nx_s = S_NEXT;
        end else begin
          state_nx_s = S_WB;
        end
      end
      // tk is the innermost index; a full ti wrap ends the run.
      S_NEXT: begin
        state_nx_s = S_LOAD;
        if (tk_r != IDX_LAST) begin
          tk_nx_s = tk_r + IDX_W'(1);
        end else begin
          tk_nx_s = '0;
          if (tj_r != IDX_LAST) begin
            tj_nx_s = tj_r + IDX_W'(1);
          end else begin
            tj_nx_s = '0;
            if (ti_r != IDX_LAST) begin
              ti_nx_s = ti_r + IDX_W'(1);
            end else begin
              ti_nx_s    = '0;
              state_nx_s = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Sticky protocol error: an array completion outside WAIT; a new start clears it.
  always_comb begin
    proto_err_nx_s = proto_err_r;
    if (bus.arr_done && (state_r != S_WAIT)) begin
      proto_err_nx_s = 1'b1;
    end else if ((state_r == S_IDLE) && bus.start) begin
      proto_err_nx_s = 1'b0;
    end else begin
      proto_err_nx_s = proto_err_r;
    end
  end

  // State, index and registered control-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= S_IDLE;
      ti_r            <= '0;
      tj_r            <= '0;
      tk_r            <= '0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      ld_valid_r      <= 1'b0;
      arr_start_r     <= 1'b0;
      arr_clear_acc_r <= 1'b0;
      wb_valid_r      <= 1'b0;
      proto_err_r     <= 1'b0;
    end else begin
      state_r         <= state_nx_s;
      ti_r            <= ti_nx_s;
      tj_r            <= tj_nx_s;
      tk_r            <= tk_nx_s;
      busy_r          <= (state_nx_s != S_IDLE);
      done_r          <= (state_nx_s == S_DONE);
      ld_valid_r      <= (state_nx_s == S_LOAD);
      arr_start_r     <= (state_nx_s == S_ISSUE);
      arr_clear_acc_r <= (state_nx_s == S_ISSUE) && (tk_nx_s == '0);
      wb_valid_r      <= (state_nx_s == S_WB);
      proto_err_r     <= proto_err_nx_s;
    end
  end

  tile_addr_gen #(
    .MATRIX_DIM (MATRIX_DIM),
    .TILE_DIM   (TILE_DIM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W),
    .POS_W      (POS_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .clr_s       (clr_s),
    .adv_s       (adv_s),
    .ld_en_s     (state_nx_s == S_LOAD),
    .wb_en_s     (state_nx_s == S_WB),
    .ti_s        (ti_nx_s),
    .tj_s        (tj_nx_s),
    .tk_s        (tk_nx_s),
    .beat_last_s (beat_last_s),
    .ld_row_r    (bus.ld_row),
    .ld_col_r    (bus.ld_col),
    .wb_row_r    (bus.wb_row),
    .wb_col_r    (bus.wb_col),
    .ld_a_addr_r (bus.ld_a_addr),
    .ld_b_addr_r (bus.ld_b_addr),
    .wb_addr_r   (bus.wb_addr)
  );

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.ld_valid      = ld_valid_r;
  assign bus.arr_start     = arr_start_r;
  assign bus.arr_clear_acc = arr_clear_acc_r;
  assign bus.wb_valid      = wb_valid_r;
  assign bus.proto_err     = proto_err_r;

endmodule
